// File: rtl/posit_pkg.sv
// ----------------------------------------------------------------------------
// posit_pkg
//   Shared constants, state encoding and a regime helper for the posit<32,3>
//   encoder.
//
//   Contents:
//     N, ES, R_MAX            posit width, exponent width, longest regime field
//     NAR                     the Not-a-Real word (sign bit only)
//     MAXPOS_BODY/MINPOS_BODY saturation bodies (31-bit, sign excluded)
//     enc_state_t             encoder FSM states
//     regime_run_length()     length of the identical-bit run for a regime k
//
//   Configuration macro used by the encoder: POSIT_ENC_RNE_EN
// ----------------------------------------------------------------------------
package posit_pkg;

    localparam int N     = 32;
    localparam int ES    = 3;
    localparam int R_MAX = 31;

    localparam logic [N-1:0] NAR         = 32'h8000_0000;
    localparam logic [N-2:0] MAXPOS_BODY = 31'h7FFF_FFFF;
    localparam logic [N-2:0] MINPOS_BODY = 31'h0000_0001;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REGIME,
        EXP_FRAC,
        ROUND,
        DONE
    } enc_state_t;

    // Number of identical regime bits before the terminator:
    // k >= 0 -> k+1 ones, k < 0 -> -k zeros. Result is 1..32.
    function automatic logic [6:0] regime_run_length(input logic [5:0] k);
        logic [6:0] k_ext;
        k_ext = {k[5], k};
        if (!k[5]) begin
            regime_run_length = k_ext + 7'd1;
        end else begin
            regime_run_length = 7'd0 - k_ext;
        end
    endfunction

endpackage

// File: rtl/posit_enc_rounder.sv
// ----------------------------------------------------------------------------
// posit_enc_rounder
//   Combinational round-to-nearest-even stage for the 31-bit posit body.
//   The body is treated as one integer, so a carry out of the fraction rolls
//   naturally into the exponent and regime fields. An overflow past maxpos
//   saturates back to maxpos, and the result is never allowed to be zero.
//
//   This module only exists when POSIT_ENC_RNE_EN is defined; the default
//   build truncates and has no use for it.
//
//   Ports:
//     body     in   31  truncated body (regime, exponent, fraction)
//     guard    in   1   first dropped tail bit
//     sticky   in   1   OR of all tail bits below guard
//     rounded  out  31  rounded, saturated body
// ----------------------------------------------------------------------------
`ifdef POSIT_ENC_RNE_EN
module posit_enc_rounder
    import posit_pkg::*;
(
    input  logic [N-2:0] body,
    input  logic         guard,
    input  logic         sticky,
    output logic [N-2:0] rounded
);

    logic         round_up;
    logic [N-1:0] sum;

    // Round up when above the halfway point, or exactly halfway with an odd
    // LSB (ties-to-even). The extra sum bit catches the maxpos overflow.
    always_comb begin
        round_up = guard && (sticky || body[0]);
        sum      = {1'b0, body} + {{(N-1){1'b0}}, round_up};
        if (sum[N-1]) begin
            rounded = MAXPOS_BODY;
        end else begin
            rounded = sum[N-2:0];
        end
        if (rounded == '0) begin
            rounded = MINPOS_BODY;
        end
    end

endmodule
`endif

// File: rtl/posit_encoder.sv
// ----------------------------------------------------------------------------
// posit_encoder
//   Sequential posit<32,3> encoder for the write-back side of the posit
//   datapath. Accepts the decoder's field format (sign, regime k, exponent,
//   mantissa with hidden 1) and packs a 32-bit sign-magnitude posit word.
//   The regime is shifted into the body one bit per cycle, then exponent and
//   fraction fill the remaining LSBs in a single step.
//
//   Configuration:
//     POSIT_ENC_RNE_EN  defined   -> extra ROUND state, round-to-nearest-even
//                       undefined -> fraction truncated, one cycle shorter
//
//   Ports:
//     clk        in   1   clock, all logic on posedge
//     rst        in   1   synchronous reset, active-low
//     start      in   1   request, sampled only while idle
//     zero       in   1   encode 0x00000000
//     nar        in   1   encode 0x80000000 (wins over zero)
//     sign       in   1   sign bit, prepended to the body
//     k          in   6   signed regime value
//     exp_value  in   3   exponent field
//     mantissa   in   32  bit 31 hidden 1 (ignored), bits 30:0 fraction
//     posit_num  out  32  encoded word, valid from done onward
//     done       out  1   one-cycle completion pulse
//     busy       out  1   high from accepted start through done
// ----------------------------------------------------------------------------
module posit_encoder
    import posit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          zero,
    input  logic          nar,
    input  logic          sign,
    input  logic [5:0]    k,
    input  logic [ES-1:0] exp_value,
    input  logic [N-1:0]  mantissa,
    output logic [N-1:0]  posit_num,
    output logic          done,
    output logic          busy
);

    enc_state_t state;

    logic          sign_r;
    logic          zero_r;
    logic          nar_r;
    logic [5:0]    k_r;
    logic [ES-1:0] exp_r;
    logic [N-2:0]  frac_r;

    logic          run_pol;
    logic [4:0]    run_len_r;
    logic [4:0]    r_len_r;
    logic [4:0]    cnt;
    logic [N-2:0]  body;

    logic [6:0]    run_full_c;
    logic [6:0]    r_full_c;
    logic [4:0]    run_len_c;
    logic [4:0]    r_len_c;
    logic          regime_bit;
    logic          sat_max;

    logic [ES+N-2:0] tail;
    logic [N-2:0]    aligned;
    logic [N-2:0]    tail_top;
    logic [N-2:0]    packed_body;

    logic hidden_bit_unused;

    assign hidden_bit_unused = mantissa[N-1];

`ifdef POSIT_ENC_RNE_EN
    logic         guard_c;
    logic         sticky_c;
    logic         guard_r;
    logic         sticky_r;
    logic [N-2:0] rounded_body;

    posit_enc_rounder u_rounder (
        .body    (body),
        .guard   (guard_r),
        .sticky  (sticky_r),
        .rounded (rounded_body)
    );
`endif

    // Regime geometry from the captured k. Both the run length and the full
    // regime field (run + terminator) are capped at 31 so an extreme k just
    // fills the body without a terminator.
    always_comb begin
        run_full_c = regime_run_length(k_r);
        r_full_c   = run_full_c + 7'd1;
        run_len_c  = (run_full_c > 7'(R_MAX)) ? 5'(R_MAX) : run_full_c[4:0];
        r_len_c    = (r_full_c > 7'(R_MAX)) ? 5'(R_MAX) : r_full_c[4:0];
    end

    // Next regime bit: the run polarity for the first run_len bits, then the
    // opposite bit as terminator.
    always_comb begin
        regime_bit = (cnt < run_len_r) ? run_pol : ~run_pol;
    end

    // Pack exponent and fraction under the regime. After the REGIME phase the
    // regime sits in body[R-1:0]; shifting it left by 31-R leaves exactly
    // 31-R free LSBs, which take the top bits of the 34-bit tail. Positive
    // saturation and the minpos floor are applied here so a nonzero value
    // never packs to zero.
    always_comb begin
        tail     = {exp_r, frac_r};
        aligned  = body << (5'(R_MAX) - r_len_r);
        tail_top = '0;
        if (r_len_r != 5'(R_MAX)) begin
            tail_top = 31'(tail >> ({1'b0, r_len_r} + 6'd3));
        end
        packed_body = aligned | tail_top;
        sat_max     = !k_r[5] && (k_r >= 6'd30);
        if (sat_max) begin
            packed_body = MAXPOS_BODY;
        end else if (packed_body == '0) begin
            packed_body = MINPOS_BODY;
        end
    end

`ifdef POSIT_ENC_RNE_EN
    // Guard is the first tail bit that did not fit; sticky collects every
    // bit below it. A full-width regime drops the tail entirely, so nothing
    // is left to round on.
    always_comb begin
        guard_c  = 1'b0;
        sticky_c = 1'b0;
        if (r_len_r != 5'(R_MAX)) begin
            guard_c  = 1'(tail >> ({1'b0, r_len_r} + 6'd2));
            sticky_c = |(tail & ((34'd1 << ({1'b0, r_len_r} + 6'd2)) - 34'd1));
        end
    end
`endif

    // Encoder FSM. Inputs are captured on the accepted start so later input
    // changes cannot disturb the word being built. done is raised on the
    // transition into DONE so it is high for exactly the DONE cycle, and busy
    // drops on the way back to IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            posit_num <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            sign_r    <= 1'b0;
            zero_r    <= 1'b0;
            nar_r     <= 1'b0;
            k_r       <= '0;
            exp_r     <= '0;
            frac_r    <= '0;
            run_pol   <= 1'b0;
            run_len_r <= '0;
            r_len_r   <= '0;
            cnt       <= '0;
            body      <= '0;
`ifdef POSIT_ENC_RNE_EN
            guard_r   <= 1'b0;
            sticky_r  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_r <= sign;
                        zero_r <= zero;
                        nar_r  <= nar;
                        k_r    <= k;
                        exp_r  <= exp_value;
                        frac_r <= mantissa[N-2:0];
                        cnt    <= '0;
                        body   <= '0;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end

                LOAD: begin
                    run_len_r <= run_len_c;
                    r_len_r   <= r_len_c;
                    run_pol   <= ~k_r[5];
                    if (nar_r) begin
                        posit_num <= NAR;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (zero_r) begin
                        posit_num <= '0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= REGIME;
                    end
                end

                REGIME: begin
                    body <= {body[N-3:0], regime_bit};
                    cnt  <= cnt + 5'd1;
                    if (cnt + 5'd1 == r_len_r) begin
                        state <= EXP_FRAC;
                    end
                end

                EXP_FRAC: begin
`ifdef POSIT_ENC_RNE_EN
                    body     <= packed_body;
                    guard_r  <= guard_c;
                    sticky_r <= sticky_c;
                    state    <= ROUND;
`else
                    posit_num <= {sign_r, packed_body};
                    done      <= 1'b1;
                    state     <= DONE;
`endif
                end

`ifdef POSIT_ENC_RNE_EN
                ROUND: begin
                    posit_num <= {sign_r, rounded_body};
                    done      <= 1'b1;
                    state     <= DONE;
                end
`endif

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_posit_encoder.sv
// ----------------------------------------------------------------------------
// tb_posit_encoder
//   Self-checking bench for posit_encoder. The expected word is derived by
//   writing regime, exponent and fraction as one long bit stream and cutting
//   it to 31 bits; the expected latency comes from the regime field length.
//   A single monitor process compares done/busy/posit_num every cycle, and
//   directed cases carry hand-computed words that pin the model.
//   Honours POSIT_ENC_RNE_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_posit_encoder;

`ifdef POSIT_ENC_RNE_EN
    localparam int RNE = 1;
`else
    localparam int RNE = 0;
`endif

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        start     = 1'b0;
    logic        zero      = 1'b0;
    logic        nar       = 1'b0;
    logic        sign      = 1'b0;
    logic [5:0]  k         = '0;
    logic [2:0]  exp_value = '0;
    logic [31:0] mantissa  = '0;
    logic [31:0] posit_num;
    logic        done;
    logic        busy;

    // Written by the stimulus process only
    logic [31:0] exp_val    = '0;
    int          exp_lat    = 0;
    logic        pin_en     = 1'b0;
    logic [31:0] pin_val    = '0;
    int          pin_lat    = 0;
    int          launch_cnt = 0;
    int          abort_cnt  = 0;

    // Written by the monitor process only
    int          n_checks     = 0;
    int          n_pass       = 0;
    int          finish_cnt   = 0;
    int          seen_launch  = 0;
    int          seen_abort   = 0;
    int          cyc_since    = 0;
    logic        active       = 1'b0;
    logic        prev_rst_low = 1'b0;

    posit_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .zero      (zero),
        .nar       (nar),
        .sign      (sign),
        .k         (k),
        .exp_value (exp_value),
        .mantissa  (mantissa),
        .posit_num (posit_num),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference word: regime pattern followed by the 34-bit tail as one
    // stream, keep the leading 31 bits, round on what fell off.
    function automatic logic [31:0] model_posit(input logic s, input logic [5:0] kk,
                                                input logic [2:0] e, input logic [31:0] m,
                                                input logic z, input logic n);
        int           k_i;
        int           run;
        int           rlen;
        int           len;
        logic [127:0] stream;
        logic [30:0]  body;
        logic         g;
        logic         st;
        if (n) return 32'h8000_0000;
        if (z) return 32'h0000_0000;
        k_i  = int'($signed(kk));
        run  = (k_i >= 0) ? k_i + 1 : -k_i;
        rlen = run + 1;
        if (k_i >= 0) stream = ((128'd1 << run) - 128'd1) << 1;
        else          stream = 128'd1;
        stream = (stream << 34) | {94'd0, e, m[30:0]};
        len    = rlen + 34;
        body   = 31'(stream >> (len - 31));
        if (rlen >= 31) begin
            g  = 1'b0;
            st = 1'b0;
        end else begin
            g  = stream[len-32];
            st = |(stream & ((128'd1 << (len - 32)) - 128'd1));
        end
        if (body == 31'd0) body = 31'd1;
        if (RNE == 1 && g && (st || body[0])) begin
            if (body != 31'h7FFF_FFFF) body = body + 31'd1;
        end
        return {s, body};
    endfunction

    function automatic int model_latency(input logic [5:0] kk, input logic z, input logic n);
        int k_i;
        int run;
        int r;
        if (z || n) return 2;
        k_i = int'($signed(kk));
        run = (k_i >= 0) ? k_i + 1 : -k_i;
        r   = (run + 1 > 31) ? 31 : run + 1;
        return 3 + r + RNE;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: actual=%h required=%h at t=%0t",
                      name, actual, expected, $time);
    endtask

    // Monitor: every negedge, decide what the outputs must be this cycle.
    // cyc_since is 1 in the cycle right after the start edge, so done is due
    // when it equals the modelled latency.
    always @(negedge clk) begin
        if (prev_rst_low) begin
            checkOutput("reset_posit_num", posit_num, 32'h0);
        end
        prev_rst_low = !rst;
        if (abort_cnt != seen_abort) begin
            seen_abort = abort_cnt;
            active     = 1'b0;
            finish_cnt = launch_cnt;
        end
        if (launch_cnt != seen_launch) begin
            seen_launch = launch_cnt;
            active      = 1'b1;
            cyc_since   = 0;
        end
        if (active) begin
            cyc_since++;
            if (cyc_since == exp_lat) begin
                checkOutput("done_at_latency", 32'(done), 32'd1);
                checkOutput("busy_at_done", 32'(busy), 32'd1);
                checkOutput("posit_num_vs_model", posit_num, exp_val);
                if (pin_en) begin
                    checkOutput("pin_model_word", exp_val, pin_val);
                    checkOutput("pin_dut_word", posit_num, pin_val);
                    checkOutput("pin_model_latency", 32'(exp_lat), 32'(pin_lat));
                end
                active     = 1'b0;
                finish_cnt = launch_cnt;
            end else begin
                checkOutput("no_early_done", 32'(done), 32'd0);
                checkOutput("busy_while_encoding", 32'(busy), 32'd1);
            end
        end else begin
            checkOutput("idle_done", 32'(done), 32'd0);
            checkOutput("idle_busy", 32'(busy), 32'd0);
        end
    end

    // Drive one request; inputs are scrambled right after the start edge to
    // prove they were captured.
    task automatic launch(input logic s, input logic [5:0] kk, input logic [2:0] e,
                          input logic [31:0] m, input logic z, input logic n,
                          input logic hold, input logic pin, input logic [31:0] pv,
                          input int pl);
        @(posedge clk); #1;
        sign      = s;
        k         = kk;
        exp_value = e;
        mantissa  = m;
        zero      = z;
        nar       = n;
        start     = 1'b1;
        exp_val   = model_posit(s, kk, e, m, z, n);
        exp_lat   = model_latency(kk, z, n);
        pin_en    = pin;
        pin_val   = pv;
        pin_lat   = pl;
        @(posedge clk); #1;
        launch_cnt++;
        if (!hold) start = 1'b0;
        sign      = 1'($urandom);
        k         = 6'($urandom);
        exp_value = 3'($urandom);
        mantissa  = $urandom;
        zero      = 1'($urandom);
        nar       = 1'($urandom);
    endtask

    task automatic waitDone();
        int i;
        i = 0;
        while (finish_cnt != launch_cnt && i < 200) begin
            @(posedge clk); #1;
            i++;
        end
        if (finish_cnt != launch_cnt) begin
            $display("[TB] FAIL wait_done: no completion within %0d cycles", i);
            $fatal(1, "[TB] encoder did not complete");
        end
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic s, input logic [5:0] kk, input logic [2:0] e,
                                 input logic [31:0] m, input logic z, input logic n,
                                 input logic hold, input logic pin, input logic [31:0] pv,
                                 input int pl);
        launch(s, kk, e, m, z, n, hold, pin, pv, pl);
        waitDone();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // k=0 plain one
        applyStimulus(1'b0, 6'd0, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0,
                      1'b1, 32'h4000_0000, 5 + RNE);
        // k=-1, exp=5, fraction 0.5, negative
        applyStimulus(1'b1, 6'h3F, 3'd5, 32'hC000_0000, 1'b0, 1'b0, 1'b0,
                      1'b1, 32'hB600_0000, 5 + RNE);
        // saturation corners
        applyStimulus(1'b0, 6'd30, 3'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,
                      1'b1, 32'h7FFF_FFFF, 34 + RNE);
        applyStimulus(1'b0, 6'h21, 3'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,
                      1'b1, 32'h0000_0001, 34 + RNE);
        applyStimulus(1'b1, 6'h22, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0,
                      1'b1, 32'h8000_0001, 34 + RNE);
        // zero and NaR overrides
        applyStimulus(1'b1, 6'd5, 3'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0,
                      1'b1, 32'h0000_0000, 2);
        applyStimulus(1'b0, 6'd5, 3'd3, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0,
                      1'b1, 32'h8000_0000, 2);
        // rounding boundary
        applyStimulus(1'b0, 6'd25, 3'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,
                      1'b1, (RNE == 1) ? 32'h7FFF_FFF0 : 32'h7FFF_FFEF, 30 + RNE);
        // start held high through the whole operation
        applyStimulus(1'b1, 6'h3F, 3'd5, 32'hC000_0000, 1'b0, 1'b0, 1'b1,
                      1'b1, 32'hB600_0000, 5 + RNE);
        repeat (4) @(posedge clk);

        // abort in REGIME via reset
        launch(1'b0, 6'd20, 3'd2, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 abort_cnt++;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        applyStimulus(1'b0, 6'd0, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0,
                      1'b1, 32'h4000_0000, 5 + RNE);

        // random fields, biased towards the regime extremes and overrides
        for (int t = 0; t < 1500; t++) begin
            int          sel;
            int          k_i;
            logic        z;
            logic        n;
            sel = int'($urandom_range(15, 0));
            if (sel == 0)      k_i = 30;
            else if (sel == 1) k_i = -31;
            else               k_i = int'($urandom_range(61, 0)) - 31;
            n = (sel == 4);
            z = (sel == 3) || (sel == 4 && $urandom_range(1, 0) == 1);
            applyStimulus(1'($urandom), 6'(k_i), 3'($urandom), $urandom, z, n,
                          (sel == 6), 1'b0, 32'h0, 0);
        end

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
